// File: rtl/fft_bin_serializer.sv
// ============================================================================
// fft_bin_serializer : captures one frame of parallel FFT bins and streams them
//                      out one bin per valid/ready beat, optionally un-bit-reversed
// Revision 1.0
// ============================================================================
`default_nettype none

module fft_bin_serializer #(
   parameter int N_POINTS = 32,
   parameter int DATA_W   = 32,
   parameter int BITREV   = 1,
   localparam int c_IDX_W = $clog2(N_POINTS)
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [N_POINTS*DATA_W-1:0]   bins_real,
   input  logic [N_POINTS*DATA_W-1:0]   bins_imag,
   input  logic                         load_valid,
   output logic                         load_ready,
   output logic [DATA_W-1:0]            out_real,
   output logic [DATA_W-1:0]            out_imag,
   output logic [c_IDX_W-1:0]           out_index,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic                         out_last,
   output logic                         busy,
   output logic [15:0]                  frame_cnt
);

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_STREAM = 1'b1
   } state_t;

   state_t               r_state;
   logic [c_IDX_W-1:0]   r_idx;
   logic [DATA_W-1:0]    r_out_real;
   logic [DATA_W-1:0]    r_out_imag;
   logic                 r_last;
   logic [15:0]          r_frame_cnt;
   logic [DATA_W-1:0]    r_buf_re [N_POINTS];
   logic [DATA_W-1:0]    r_buf_im [N_POINTS];

   logic                 w_load;
   logic [c_IDX_W-1:0]   w_next_idx;
   logic [c_IDX_W-1:0]   w_next_slot;

   // Storage slot that holds natural bin i.
   function automatic logic [c_IDX_W-1:0] f_slot(input logic [c_IDX_W-1:0] i);
      logic [c_IDX_W-1:0] r;
      r = i;
      if (BITREV != 0) begin
         for (int b = 0; b < c_IDX_W; b++) begin
            r[b] = i[c_IDX_W-1-b];
         end
      end
      return r;
   endfunction

   // During the last beat the next frame can be taken in the same cycle.
   assign load_ready  = (r_state == ST_IDLE) | (r_last & out_ready);
   assign w_load      = load_valid & load_ready;
   assign w_next_idx  = r_idx + c_IDX_W'(1);
   assign w_next_slot = f_slot(w_next_idx);

   generate
      for (genvar k = 0; k < N_POINTS; k++) begin : g_slot
         always_ff @(posedge clk) begin
            if (w_load) begin
               r_buf_re[k] <= bins_real[k*DATA_W +: DATA_W];
               r_buf_im[k] <= bins_imag[k*DATA_W +: DATA_W];
            end
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state     <= ST_IDLE;
         r_idx       <= '0;
         r_out_real  <= '0;
         r_out_imag  <= '0;
         r_last      <= 1'b0;
         r_frame_cnt <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (load_valid) begin
                  // Natural bin 0 always lives in slot 0, so take it straight from the inputs.
                  r_state    <= ST_STREAM;
                  r_idx      <= '0;
                  r_out_real <= bins_real[DATA_W-1:0];
                  r_out_imag <= bins_imag[DATA_W-1:0];
                  r_last     <= 1'b0;
               end
            end
            ST_STREAM: begin
               if (out_ready) begin
                  if (r_last) begin
                     r_frame_cnt <= r_frame_cnt + 16'd1;
                     r_idx       <= '0;
                     r_last      <= 1'b0;
                     if (load_valid) begin
                        r_out_real <= bins_real[DATA_W-1:0];
                        r_out_imag <= bins_imag[DATA_W-1:0];
                     end else begin
                        r_state <= ST_IDLE;
                     end
                  end else begin
                     r_idx      <= w_next_idx;
                     r_out_real <= r_buf_re[w_next_slot];
                     r_out_imag <= r_buf_im[w_next_slot];
                     r_last     <= (w_next_idx == c_IDX_W'(N_POINTS-1));
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign out_valid = (r_state == ST_STREAM);
   assign busy      = (r_state == ST_STREAM);
   assign out_index = r_idx;
   assign out_real  = r_out_real;
   assign out_imag  = r_out_imag;
   assign out_last  = r_last;
   assign frame_cnt = r_frame_cnt;

endmodule

`default_nettype wire

// File: tb/tb_fft_bin_serializer.sv
// ============================================================================
// tb_fft_bin_serializer : self-checking bench with a beat-queue reference model
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_fft_bin_serializer;

   localparam int N  = 32;
   localparam int W  = 32;
   localparam int N8 = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst_n;
   logic [N*W-1:0]    bins_re, bins_im;
   logic              lv, ordy;
   logic              ld_rdy, o_val, o_last, o_busy;
   logic [W-1:0]      o_re, o_im;
   logic [4:0]        o_idx;
   logic [15:0]       o_cnt;

   logic [N8*W-1:0]   bins8_re, bins8_im;
   logic              lv8, or8;
   logic              ld_rdy8, o8_val, o8_last, o8_busy;
   logic [W-1:0]      o8_re, o8_im;
   logic [2:0]        o8_idx;
   logic [15:0]       o8_cnt;

   fft_bin_serializer #(.N_POINTS(N), .DATA_W(W), .BITREV(1)) dut (
      .clk(clk), .reset(rst_n), .bins_real(bins_re), .bins_imag(bins_im),
      .load_valid(lv), .load_ready(ld_rdy), .out_real(o_re), .out_imag(o_im),
      .out_index(o_idx), .out_valid(o_val), .out_ready(ordy), .out_last(o_last),
      .busy(o_busy), .frame_cnt(o_cnt));

   fft_bin_serializer #(.N_POINTS(N8), .DATA_W(W), .BITREV(0)) dut8 (
      .clk(clk), .reset(rst_n), .bins_real(bins8_re), .bins_imag(bins8_im),
      .load_valid(lv8), .load_ready(ld_rdy8), .out_real(o8_re), .out_imag(o8_im),
      .out_index(o8_idx), .out_valid(o8_val), .out_ready(or8), .out_last(o8_last),
      .busy(o8_busy), .frame_cnt(o8_cnt));

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   // Reference model: a queue of the beats still to be presented, in order.
   typedef struct {
      int         idx;
      logic [W-1:0] re;
      logic [W-1:0] im;
      bit         last;
   } beat_t;

   beat_t        q[$];
   logic [15:0]  m_cnt;
   logic [W-1:0] sre[N];
   logic [W-1:0] sim[N];

   function automatic int brev(input int v, input int bits);
      int r = 0;
      for (int b = 0; b < bits; b++) begin
         r = r * 2 + (v % 2);
         v = v / 2;
      end
      return r;
   endfunction

   task automatic drive_bins();
      for (int k = 0; k < N; k++) begin
         bins_re[k*W +: W] = sre[k];
         bins_im[k*W +: W] = sim[k];
      end
   endtask

   task automatic push_frame();
      beat_t b;
      for (int i = 0; i < N; i++) begin
         b.idx  = i;
         b.re   = sre[brev(i, 5)];
         b.im   = sim[brev(i, 5)];
         b.last = (i == N - 1);
         q.push_back(b);
      end
   endtask

   task automatic rand_frame();
      for (int k = 0; k < N; k++) begin
         sre[k] = $urandom();
         sim[k] = $urandom();
      end
   endtask

   task automatic check_outputs();
      chk("out_valid", o_val, q.size() > 0);
      chk("busy", o_busy, q.size() > 0);
      chk("frame_cnt", o_cnt, m_cnt);
      if (q.size() > 0) begin
         chk("out_index", o_idx, q[0].idx);
         chk("out_real", o_re, q[0].re);
         chk("out_imag", o_im, q[0].im);
         chk("out_last", o_last, q[0].last);
      end
   endtask

   task automatic cycle(input logic v, input logic r);
      bit exp_rdy, hs_out, hs_ld;
      lv   = v;
      ordy = r;
      drive_bins();
      exp_rdy = (q.size() == 0) || (q[0].last && r);
      #1 chk("load_ready", ld_rdy, exp_rdy);
      hs_out = (q.size() > 0) && r;
      hs_ld  = v && exp_rdy;
      @(posedge clk);
      if (hs_out) begin
         if (q[0].last) m_cnt++;
         void'(q.pop_front());
      end
      if (hs_ld) push_frame();
      #1 check_outputs();
   endtask

   task automatic do_reset(input int n);
      lv    = 1'b0;
      ordy  = 1'b0;
      rst_n = 1'b0;
      repeat (n) @(posedge clk);
      q.delete();
      m_cnt = '0;
      #1 rst_n = 1'b1;
   endtask

   typedef struct {
      logic lv;
      logic ordy;
      logic rdy;
      logic val;
      int   idx;
      logic last;
      int   cnt;
   } vec_t;

   vec_t tbl[12];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bit b_loaded;
      int beats;
      int hcnt[N];
      logic [15:0] cnt_start;

      tbl[0]  = '{1'b1, 1'b0, 1'b1, 1'b1, 0, 1'b0, 0};
      tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1, 1'b0, 0};
      tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b1, 2, 1'b0, 0};
      tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 2, 1'b0, 0};
      tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 3, 1'b0, 0};
      tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b1, 4, 1'b0, 0};
      tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 5, 1'b0, 0};
      tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 6, 1'b0, 0};
      tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 7, 1'b1, 0};
      tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 7, 1'b1, 0};
      tbl[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1};
      tbl[11] = '{1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1};

      rst_n = 1'b0; lv = 1'b0; ordy = 1'b0; lv8 = 1'b0; or8 = 1'b0;
      for (int k = 0; k < N; k++) begin
         sre[k] = k;
         sim[k] = 100 + k;
      end
      for (int k = 0; k < N8; k++) begin
         bins8_re[k*W +: W] = k;
         bins8_im[k*W +: W] = 50 + k;
      end
      drive_bins();
      @(posedge clk);
      #1;

      // Reset state
      do_reset(3);
      @(posedge clk);
      #1;
      chk("rst load_ready", ld_rdy, 1);
      chk("rst out_valid", o_val, 0);
      chk("rst frame_cnt", o_cnt, 0);
      chk("rst out_real", o_re, 0);
      chk("rst out_imag", o_im, 0);
      chk("rst out_index", o_idx, 0);
      chk("rst out_last", o_last, 0);
      chk("rst busy", o_busy, 0);

      // Ramp frame, continuous ready
      cycle(1'b1, 1'b1);
      for (int i = 0; i < N; i++) begin
         if (i == 1) chk("ramp beat1 real", o_re, 16);
         if (i == 3) chk("ramp beat3 real", o_re, 24);
         cycle(1'b0, 1'b1);
      end
      chk("ramp frame_cnt", o_cnt, 1);

      // Backpressure on beats 0, 7 and 31
      rand_frame();
      for (int k = 0; k < N; k++) hcnt[k] = 0;
      beats = 0;
      cycle(1'b1, 1'b1);
      for (int c = 0; c < 300 && q.size() > 0; c++) begin
         if ((q[0].idx == 0 || q[0].idx == 7 || q[0].idx == 31) && hcnt[q[0].idx] < 4) begin
            hcnt[q[0].idx]++;
            cycle(1'b0, 1'b0);
         end else begin
            beats++;
            cycle(1'b0, 1'b1);
         end
      end
      chk("bp beats", beats, 32);
      chk("bp drained", q.size(), 0);

      // Back-to-back frames
      cnt_start = m_cnt;
      rand_frame();
      cycle(1'b1, 1'b1);
      rand_frame();
      b_loaded = 0;
      for (int c = 0; c < 100 && !b_loaded; c++) begin
         if (q.size() > 0 && q[0].last) b_loaded = 1;
         cycle(1'b1, 1'b1);
      end
      chk("b2b loaded", b_loaded, 1);
      chk("b2b no bubble", o_val, 1);
      chk("b2b B index", o_idx, 0);
      chk("b2b B real", o_re, sre[0]);
      for (int c = 0; c < 100 && q.size() > 0; c++) cycle(1'b0, 1'b1);
      chk("b2b frame_cnt", o_cnt, cnt_start + 16'd2);

      // Mid-stream reset at beat 12
      do_reset(1);
      rand_frame();
      cycle(1'b1, 1'b1);
      for (int c = 0; c < 50 && q.size() > 0 && q[0].idx != 12; c++) cycle(1'b0, 1'b1);
      chk("mid reached 12", o_idx, 12);
      rst_n = 1'b0; lv = 1'b0; ordy = 1'b1;
      @(posedge clk);
      q.delete();
      #1 rst_n = 1'b1;
      chk("mid out_valid", o_val, 0);
      chk("mid load_ready", ld_rdy, 1);
      chk("mid frame_cnt", o_cnt, 0);
      rand_frame();
      cycle(1'b1, 1'b1);
      chk("mid restart valid", o_val, 1);
      chk("mid restart index", o_idx, 0);
      for (int c = 0; c < 100 && q.size() > 0; c++) cycle(1'b0, 1'b1);

      // Randomized traffic against the model
      for (int c = 0; c < 1500; c++) begin
         rand_frame();
         cycle($urandom_range(0, 3) == 0, $urandom_range(0, 9) < 7);
      end
      for (int c = 0; c < 200 && q.size() > 0; c++) cycle(1'b0, 1'b1);
      chk("rand drained", q.size(), 0);

      // 8-point natural-order build, table-driven
      for (int i = 0; i < 12; i++) begin
         lv8 = tbl[i].lv;
         or8 = tbl[i].ordy;
         #1 chk($sformatf("n8[%0d] load_ready", i), ld_rdy8, tbl[i].rdy);
         @(posedge clk);
         #1;
         chk($sformatf("n8[%0d] out_valid", i), o8_val, tbl[i].val);
         chk($sformatf("n8[%0d] frame_cnt", i), o8_cnt, tbl[i].cnt);
         if (tbl[i].val) begin
            chk($sformatf("n8[%0d] out_index", i), o8_idx, tbl[i].idx);
            chk($sformatf("n8[%0d] out_real", i), o8_re, tbl[i].idx);
            chk($sformatf("n8[%0d] out_imag", i), o8_im, 50 + tbl[i].idx);
            chk($sformatf("n8[%0d] out_last", i), o8_last, tbl[i].last);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
